// File: rtl/uart8_tx_pkg.sv
// Shared encodings and frame constants for the 8-bit serial transmitter.
package uart8_tx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  localparam logic START_LVL = 1'b0;
  localparam logic STOP_LVL  = 1'b1;
  localparam int   DATA_BITS = 8;

endpackage

// File: rtl/uart8_tx_if.sv
// Load/Ready byte handshake plus the serial line and frame-done strobe.
interface uart8_tx_if;
  logic [7:0] Tx_In;
  logic       Load;
  logic       Ready;
  logic       Tx_Out;
  logic       Done;

  modport master (output Tx_In, Load, input Ready, Tx_Out, Done);
  modport slave  (input Tx_In, Load, output Ready, Tx_Out, Done);
endinterface

// File: rtl/uart8_tx_shift8_piso.sv
// 8-bit parallel-load / shift-right register assembled from flop and 2:1 mux cells.
module dflipflop (
  input  logic clk,
  input  logic res,
  input  logic d,
  output logic q
);
  always_ff @(posedge clk) begin
    if (res) q <= 1'b0;
    else     q <= d;
  end
endmodule

module mux2 (
  input  logic a,
  input  logic b,
  input  logic s,
  output logic y
);
  assign y = s ? b : a;
endmodule

module shift8_piso (
  input  logic       clk,
  input  logic       res,
  input  logic       Ld,
  input  logic       Sh,
  input  logic [7:0] D,
  output logic       Q0
);
  logic [7:0] q, sr, sh_d, nx;

  // Zero enters at the top as bits drain out of bit 0.
  assign sr = {1'b0, q[7:1]};

  mux2      u_sh [7:0] (.a(q),    .b(sr), .s(Sh), .y(sh_d));
  mux2      u_ld [7:0] (.a(sh_d), .b(D),  .s(Ld), .y(nx));
  dflipflop u_ff [7:0] (.clk(clk), .res(res), .d(nx), .q(q));

  assign Q0 = q[0];
endmodule

// File: rtl/uart8_tx.sv
// Framed serial transmitter: start bit, 8 data bits LSB first, stop bit.
module uart8_tx
  import uart8_tx_pkg::*;
#(
  parameter int BIT_CYCLES = 4
) (
  input  logic       clk,
  input  logic       res,
  uart8_tx_if.slave  bus
);
  localparam logic [7:0] LAST = 8'(BIT_CYCLES - 1);

  state_t     state, state_nx;
  logic [7:0] cnt, cnt_nx;
  logic [2:0] idx, idx_nx;
  logic       tx_q, rdy_q, done_q;
  logic       tx_nx, rdy_nx, done_nx;
  logic       ld, sh, q0, bit_end;

  assign bit_end = (cnt == LAST);

  // The line flop is loaded with the next bit at each boundary, so the shift
  // register runs one bit ahead of the line and only Q0 needs to be visible.
  shift8_piso u_shift (
    .clk (clk),
    .res (res),
    .Ld  (ld),
    .Sh  (sh),
    .D   (bus.Tx_In),
    .Q0  (q0)
  );

  always_ff @(posedge clk) begin
    if (res) begin
      state  <= IDLE;
      cnt    <= '0;
      idx    <= '0;
      tx_q   <= STOP_LVL;
      rdy_q  <= 1'b1;
      done_q <= 1'b0;
    end else begin
      state  <= state_nx;
      cnt    <= cnt_nx;
      idx    <= idx_nx;
      tx_q   <= tx_nx;
      rdy_q  <= rdy_nx;
      done_q <= done_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = bit_end ? 8'd0 : 8'(cnt + 8'd1);
    idx_nx   = idx;
    tx_nx    = tx_q;
    rdy_nx   = 1'b0;
    done_nx  = 1'b0;
    ld       = 1'b0;
    sh       = 1'b0;
    case (state)
      IDLE: begin
        cnt_nx = '0;
        tx_nx  = STOP_LVL;
        rdy_nx = 1'b1;
        if (bus.Load) begin
          ld       = 1'b1;
          state_nx = START;
          tx_nx    = START_LVL;
          rdy_nx   = 1'b0;
        end
      end
      START: begin
        tx_nx = START_LVL;
        if (bit_end) begin
          state_nx = DATA;
          idx_nx   = '0;
          tx_nx    = q0;
          sh       = 1'b1;
        end
      end
      DATA: begin
        if (bit_end) begin
          sh     = 1'b1;
          idx_nx = 3'(idx + 3'd1);
          if (idx == 3'(DATA_BITS - 1)) begin
            state_nx = STOP;
            tx_nx    = STOP_LVL;
          end else begin
            tx_nx = q0;
          end
        end
      end
      STOP: begin
        tx_nx = STOP_LVL;
        if (bit_end) begin
          state_nx = IDLE;
          rdy_nx   = 1'b1;
          done_nx  = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign bus.Tx_Out = tx_q;
  assign bus.Ready  = rdy_q;
  assign bus.Done   = done_q;
endmodule
